uart_rx_pkt_fifo: RTL and testbench
===================================

Name: uart_rx_pkt_fifo

Overview:
Downstream consumer of the UART receiver. Takes its one-cycle byte strobes and end-of-packet pulses and assembles bytes into a packet-delimited FIFO with a last flag per byte. Drains over a valid/ready stream toward the command parser or host bridge. Reports buffered packet count, sticky overflow, and a saturating dropped-byte counter.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 4
AW, log2(DEPTH), pointer width (derived localparam, not overridable)

Ports:
clk  in  1  system clock, same domain as the receiver
rst_n  in  1  asynchronous active-low reset
rx_data_ready  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
rx_endofpacket  in  1  one-cycle pulse: line went idle after traffic
m_valid  out  1  output byte available
m_data  out  8  output byte (FIFO head)
m_last  out  1  head byte is the final byte of its packet
m_ready  in  1  consumer accepts head when m_valid && m_ready
level  out  AW+1  committed FIFO entries, 0..DEPTH
pkt_count  out  AW+1  entries in FIFO with last=1, i.e. complete packets
overflow  out  1  sticky: a byte was dropped
ovf_clear  in  1  clears overflow and drop_count
drop_count  out  8  dropped bytes, saturates at 255

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, pkt_count=0, staging empty, m_valid=0, m_data=0, m_last=0, overflow=0, drop_count=0.
- Staging register: holds the most recent byte because its last flag is unknown until the next event.
  - rx_data_ready with staging empty: byte loaded into staging. Nothing committed.
  - rx_data_ready with staging full: staged byte committed with last=0; new byte loaded into staging.
  - rx_endofpacket with staging full: staged byte committed with last=1; staging emptied.
  - rx_endofpacket with staging empty: ignored. This covers the spurious pulse after power-up and back-to-back idle pulses.
  - rx_data_ready and rx_endofpacket in the same cycle: staged byte (if any) committed with last=1; new byte loaded into staging.
- Commit: writes {last,data} at wr_ptr and increments wr_ptr (wraps mod DEPTH). Allowed when level<DEPTH, or when a pop occurs in the same cycle.
  - Commit refused (full, no pop): the byte is discarded, overflow<=1, drop_count increments (saturating).
  - If the discarded byte had last=1, the previous committed byte is NOT retro-marked; the consumer sees a merged packet. Documented limitation.
- Pop: m_valid && m_ready. Increments rd_ptr (wraps). Head is first-word-fall-through from the array: m_valid = (level!=0), and m_data/m_last are the head entry.
  - Latency: commit in cycle N makes the entry visible (m_valid=1 if it was empty) in cycle N+1.
- level: +1 on commit, -1 on pop, unchanged when both occur.
- pkt_count: +1 on a last=1 commit, -1 on a last=1 pop, unchanged when both occur.
- m_data/m_last are stable while m_valid && !m_ready.
- ovf_clear: overflow<=0 and drop_count<=0. A same-cycle drop takes priority, so the result is overflow=1, drop_count=1.
- Reset mid-packet: FIFO and staging contents are discarded; no partial state survives.

Test Plan:
- Send bytes 0x11,0x22,0x33, then rx_endofpacket, with m_ready=1. Required: m_data sequence 11,22,33 with m_last=0,0,1. pkt_count pulses 0->1->0. level returns to 0.
- After reset, rx_endofpacket with no data. Required: level=0, pkt_count=0, m_valid stays 0.
- DEPTH=16, m_ready=0, send 18 bytes then eop. Required: level=16 and overflow=1. drop_count=2: the 17th byte and the eop-committed 18th byte. Head 0x00..0x0F is intact.
- FIFO full, m_ready=1 in the same cycle as a commit. Required: no drop, level stays 16, overflow stays 0.
- Byte 0xA5 and rx_endofpacket in the same cycle, with staging holding 0x5A. Required: 0x5A popped with m_last=1; 0xA5 remains staged with level unchanged until the next event.
- Assert rst_n low mid-packet with level=5. Required: all outputs reach their reset values immediately, without waiting for a clock edge. The next packet, 0x01 then eop, comes out alone with m_last=1.

Source files
------------

// File: rtl/uart_rx_pkt_fifo.sv
// Purpose: assembles UART receiver byte strobes into a packet-delimited FIFO with a last flag per byte.
// Latency: a byte becomes visible at the head one cycle after it is committed from staging.
// Backpressure: m_valid/m_ready drain; when the FIFO is full and nothing pops, committed bytes are dropped and counted.
module uart_rx_pkt_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_data_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_endofpacket,
    output logic                   m_valid,
    output logic [7:0]             m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] pkt_count,
    output logic                   overflow,
    input  logic                   ovf_clear,
    output logic [7:0]             drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    // Each entry is {last, data}.
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   pkt_q, pkt_d;
    logic          stg_vld_q, stg_vld_d;
    logic [7:0]    stg_dat_q, stg_dat_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    logic          has_data;
    logic          head_last;
    logic          pop;
    logic          commit_req;
    logic          commit_last;
    logic          commit_ok;
    logic          drop;

    // The staged byte only learns its last flag at the next strobe or end-of-packet,
    // so any event that finds staging occupied pushes the staged byte out.
    assign has_data    = (level_q != '0);
    assign head_last   = mem_q[rd_ptr_q][8];
    assign pop         = has_data && m_ready;
    assign commit_req  = stg_vld_q && (rx_data_ready || rx_endofpacket);
    assign commit_last = rx_endofpacket;
    assign commit_ok   = commit_req && ((level_q != FULL_LVL) || pop);
    assign drop        = commit_req && !commit_ok;

    // Head is read straight from the array; gating on level keeps outputs at zero
    // whenever the FIFO is empty, including immediately on reset.
    assign m_valid    = has_data;
    assign m_data     = has_data ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign m_last     = has_data ? head_last : 1'b0;
    assign level      = level_q;
    assign pkt_count  = pkt_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

    // Next-state for pointers, occupancy, staging and drop accounting.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_d     = pkt_q;
        stg_vld_d = stg_vld_q;
        stg_dat_d = stg_dat_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;

        if (commit_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;

        if (commit_ok && !pop)      level_d = level_q + ONE_LVL;
        else if (!commit_ok && pop) level_d = level_q - ONE_LVL;

        if ((commit_ok && commit_last) && !(pop && head_last))      pkt_d = pkt_q + ONE_LVL;
        else if (!(commit_ok && commit_last) && (pop && head_last)) pkt_d = pkt_q - ONE_LVL;

        if (rx_data_ready) begin
            stg_vld_d = 1'b1;
            stg_dat_d = rx_data;
        end else if (rx_endofpacket) begin
            stg_vld_d = 1'b0;
        end

        // A drop in the same cycle as a clear wins: the new drop is the first one counted.
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = ovf_clear ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end else if (ovf_clear) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    // Control state with async reset; a reset discards any partially assembled packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_q     <= '0;
            stg_vld_q <= 1'b0;
            stg_dat_q <= 8'h00;
            ovf_q     <= 1'b0;
            drop_q    <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_q     <= pkt_d;
            stg_vld_q <= stg_vld_d;
            stg_dat_q <= stg_dat_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    // Storage array; contents are don't-care until level covers them, so no reset.
    always_ff @(posedge clk) begin
        if (commit_ok) mem_q[wr_ptr_q] <= {commit_last, stg_dat_q};
    end
endmodule

// File: tb/tb_uart_rx_pkt_fifo.sv
// Purpose: directed self-checking bench for uart_rx_pkt_fifo (DEPTH=16).
// Latency: inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Backpressure: m_ready driven per scenario to exercise full, drain and pop-during-commit cases.
module tb_uart_rx_pkt_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_endofpacket = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b0;
    logic [4:0] level;
    logic [4:0] pkt_count;
    logic       overflow;
    logic       ovf_clear = 1'b0;
    logic [7:0] drop_count;

    int total = 0;
    int bad = 0;

    uart_rx_pkt_fifo #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data_ready(rx_data_ready), .rx_data(rx_data), .rx_endofpacket(rx_endofpacket),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .level(level), .pkt_count(pkt_count), .overflow(overflow),
        .ovf_clear(ovf_clear), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_data_ready = 1'b0; rx_endofpacket = 1'b0; ovf_clear = 1'b0; m_ready = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_ready = 1'b1; rx_data = b;
        step();
        rx_data_ready = 1'b0;
    endtask

    task automatic send_eop();
        rx_endofpacket = 1'b1;
        step();
        rx_endofpacket = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        total++; if ({m_data, m_last} !== 9'h000) begin bad++; $display("FAIL reset_head got=%h/%0b exp=00/0", m_data, m_last); end
        total++; if ({level, pkt_count} !== 10'd0) begin bad++; $display("FAIL reset_counts level=%0d pkt=%0d exp=0/0", level, pkt_count); end
        total++; if ({overflow, drop_count} !== 9'd0) begin bad++; $display("FAIL reset_ovf got=%0b/%0d exp=0/0", overflow, drop_count); end
    endtask

    task automatic test_basic_packet();
        do_reset();
        m_ready = 1'b1;
        send_byte(8'h11);
        total++; if (level !== 5'd0) begin bad++; $display("FAIL basic_staged_level got=%0d exp=0", level); end
        send_byte(8'h22);
        total++; if ({m_valid, m_data, m_last} !== {1'b1, 8'h11, 1'b0}) begin bad++; $display("FAIL basic_b0 got=%0b/%h/%0b exp=1/11/0", m_valid, m_data, m_last); end
        send_byte(8'h33);
        total++; if ({m_data, m_last, level} !== {8'h22, 1'b0, 5'd1}) begin bad++; $display("FAIL basic_b1 got=%h/%0b/%0d exp=22/0/1", m_data, m_last, level); end
        send_eop();
        total++; if ({m_data, m_last, pkt_count} !== {8'h33, 1'b1, 5'd1}) begin bad++; $display("FAIL basic_b2 got=%h/%0b pkt=%0d exp=33/1/1", m_data, m_last, pkt_count); end
        step();
        total++; if ({m_valid, level, pkt_count} !== {1'b0, 5'd0, 5'd0}) begin bad++; $display("FAIL basic_drained got=%0b/%0d/%0d exp=0/0/0", m_valid, level, pkt_count); end
    endtask

    task automatic test_spurious_eop();
        do_reset();
        send_eop();
        send_eop();
        step();
        total++; if ({m_valid, level, pkt_count} !== {1'b0, 5'd0, 5'd0}) begin bad++; $display("FAIL spurious_eop got=%0b/%0d/%0d exp=0/0/0", m_valid, level, pkt_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) send_byte(8'(i));
        send_eop();
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
        total++; if ({overflow, drop_count} !== {1'b1, 8'd2}) begin bad++; $display("FAIL ovf_drops got=%0b/%0d exp=1/2", overflow, drop_count); end
        total++; if (pkt_count !== 5'd0) begin bad++; $display("FAIL ovf_pkt got=%0d exp=0", pkt_count); end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({m_valid, m_data, m_last} !== {1'b1, 8'(i), 1'b0}) begin
                bad++; $display("FAIL ovf_head[%0d] got=%0b/%h/%0b exp=1/%h/0", i, m_valid, m_data, m_last, 8'(i));
            end
            step();
        end
        m_ready = 1'b0;
        total++; if ({m_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL ovf_drained got=%0b/%0d exp=0/0", m_valid, level); end
        ovf_clear = 1'b1; step(); ovf_clear = 1'b0;
        total++; if ({overflow, drop_count} !== 9'd0) begin bad++; $display("FAIL ovf_clear got=%0b/%0d exp=0/0", overflow, drop_count); end
    endtask

    task automatic test_full_with_pop();
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'h40 + 8'(i));
        total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
        m_ready = 1'b1;
        send_byte(8'h60);
        m_ready = 1'b0;
        total++; if ({level, overflow, drop_count} !== {5'd16, 1'b0, 8'd0}) begin bad++; $display("FAIL full_pop got=%0d/%0b/%0d exp=16/0/0", level, overflow, drop_count); end
        total++; if (m_data !== 8'h41) begin bad++; $display("FAIL full_pop_head got=%h exp=41", m_data); end
        rx_data_ready = 1'b1; rx_data = 8'h61; ovf_clear = 1'b1;
        step();
        rx_data_ready = 1'b0; ovf_clear = 1'b0;
        total++; if ({overflow, drop_count} !== {1'b1, 8'd1}) begin bad++; $display("FAIL drop_beats_clear got=%0b/%0d exp=1/1", overflow, drop_count); end
    endtask

    task automatic test_same_cycle_eop();
        do_reset();
        send_byte(8'h5A);
        rx_data_ready = 1'b1; rx_data = 8'hA5; rx_endofpacket = 1'b1;
        step();
        rx_data_ready = 1'b0; rx_endofpacket = 1'b0;
        total++; if ({level, m_data, m_last, pkt_count} !== {5'd1, 8'h5A, 1'b1, 5'd1}) begin bad++; $display("FAIL same_cycle got=%0d/%h/%0b/%0d exp=1/5a/1/1", level, m_data, m_last, pkt_count); end
        m_ready = 1'b1;
        step(); step(); step();
        total++; if ({m_valid, level, pkt_count} !== {1'b0, 5'd0, 5'd0}) begin bad++; $display("FAIL same_cycle_staged got=%0b/%0d/%0d exp=0/0/0", m_valid, level, pkt_count); end
        m_ready = 1'b0;
        send_eop();
        total++; if ({m_valid, m_data, m_last} !== {1'b1, 8'hA5, 1'b1}) begin bad++; $display("FAIL same_cycle_tail got=%0b/%h/%0b exp=1/a5/1", m_valid, m_data, m_last); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i));
        total++; if (level !== 5'd5) begin bad++; $display("FAIL mid_level got=%0d exp=5", level); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({m_valid, m_data, m_last, level, pkt_count} !== 20'd0) begin bad++; $display("FAIL mid_async got=%0b/%h/%0b/%0d/%0d exp=0/00/0/0/0", m_valid, m_data, m_last, level, pkt_count); end
        step();
        rst_n = 1'b1;
        step();
        send_byte(8'h01);
        send_eop();
        total++; if ({m_valid, m_data, m_last, level, pkt_count} !== {1'b1, 8'h01, 1'b1, 5'd1, 5'd1}) begin bad++; $display("FAIL mid_next_pkt got=%0b/%h/%0b/%0d/%0d exp=1/01/1/1/1", m_valid, m_data, m_last, level, pkt_count); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        total++; if ({m_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL mid_alone got=%0b/%0d exp=0/0", m_valid, level); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_packet();
        test_spurious_eop();
        test_overflow();
        test_full_with_pop();
        test_same_cycle_eop();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
